// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered single-cycle ops plus iterative
// multiply / unsigned divide / remainder, one operation in flight.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       comp,
  output logic             div0,
  output logic             illegal
);

  localparam int unsigned CNT_W = SHW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_DIV = 4'b1011;
  localparam logic [3:0] OP_REM = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, quo_q, quo_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [2:0]         comp_q, comp_d;
  logic               div0_q, div0_d, illegal_q, illegal_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   single_res;
  logic [2:0]         cmp;
  logic [CNT_W-1:0]   bit_idx;
  logic [WIDTH-1:0]   mul_nxt, rem_nxt, quo_nxt;
  logic [WIDTH:0]     trial, diff;
  logic               is_iter, is_illegal;

  // Datapath for single-cycle ops, flags and one iteration of mul/div
  always_comb begin
    sh         = b_q[SHW-1:0];
    is_iter    = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    is_illegal = (op_q > OP_REM);
    cmp        = {$signed(a_q) > $signed(b_q), a_q == b_q, $signed(a_q) < $signed(b_q)};
    single_res = '0;
    case (op_q)
      OP_ADD:  single_res = a_q + b_q;
      OP_SUB:  single_res = a_q - b_q;
      OP_AND:  single_res = a_q & b_q;
      OP_OR:   single_res = a_q | b_q;
      OP_XOR:  single_res = a_q ^ b_q;
      OP_NOT:  single_res = ~a_q;
      OP_SLL:  single_res = a_q << sh;
      OP_SRA:  single_res = $unsigned($signed(a_q) >>> sh);
      OP_SRL:  single_res = a_q >> sh;
      default: single_res = '0;
    endcase
    bit_idx = CNT_MAX - cnt_q;
    mul_nxt = (acc_q << 1) + (b_q[bit_idx] ? a_q : '0);
    // Restoring step: a zero divisor always "fits", giving all-ones / A
    trial   = {acc_q, a_q[bit_idx]};
    diff    = trial - {1'b0, b_q};
    rem_nxt = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    out_d     = out_q;
    comp_d    = comp_q;
    div0_d    = div0_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = '0;
          acc_d   = '0;
          quo_d   = '0;
          state_d = is_iter ? S_BUSY : S_EXEC;
        end
      end
      S_EXEC: begin
        out_d     = single_res;
        comp_d    = cmp;
        div0_d    = 1'b0;
        illegal_d = is_illegal;
        state_d   = S_DONE;
      end
      S_BUSY: begin
        acc_d = (op_q == OP_MUL) ? mul_nxt : rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_MAX) begin
          cnt_d     = '0;
          out_d     = (op_q == OP_MUL) ? mul_nxt : (op_q == OP_DIV) ? quo_nxt : rem_nxt;
          comp_d    = cmp;
          div0_d    = (op_q != OP_MUL) && (b_q == '0);
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      out_q       <= '0;
      comp_q      <= '0;
      div0_q      <= 1'b0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      out_q       <= out_d;
      comp_q      <= comp_d;
      div0_q      <= div0_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign comp      = comp_q;
  assign div0      = div0_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=16: results, flags, latency,
// backpressure and mid-operation reset.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [2:0]  comp;
  logic        div0;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .comp(comp), .div0(div0), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [2:0]  comp;
    logic        div0;
    logic        ill;
    int          lat;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, keep garbage on the inputs while busy, then check result
  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready before issue"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = v.a; b = v.b; op = v.op; out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
    chk({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && in_ready) begin
        checks++; errors++;
        $display("FAIL %s in_ready high while busy at cycle %0d", tag, lat);
      end
      a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " out"}, 32'(out), 32'(v.out));
    chk({tag, " comp"}, 32'(comp), 32'(v.comp));
    chk({tag, " div0"}, 32'(div0), 32'(v.div0));
    chk({tag, " illegal"}, 32'(illegal), 32'(v.ill));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " hold out"}, 32'({out, comp, div0, illegal}), 32'({v.out, v.comp, v.div0, v.ill}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    chk({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    //          op       A         B         out       comp    d0    ill   lat
    vecs[0]  = '{4'b0001, 16'd5,    16'd2,    16'd3,    3'b100, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'b0001, 16'd2,    16'd5,    16'hFFFD, 3'b001, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'b0001, 16'd5,    16'd5,    16'h0000, 3'b010, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'b1001, 16'hFFFA, 16'h0002, 16'h0000, 3'b001, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'b1001, 16'hFFFB, 16'hFFFA, 16'h0000, 3'b100, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'b0000, 16'd3,    16'd4,    16'd7,    3'b001, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'b0010, 16'hF0F0, 16'hFF00, 16'hF000, 3'b001, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'b0011, 16'h00F0, 16'h0F00, 16'h0FF0, 3'b001, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'b0100, 16'hFFFF, 16'h00FF, 16'hFF00, 3'b001, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'b0101, 16'h1234, 16'h0000, 16'hEDCB, 3'b100, 1'b0, 1'b0, 1};
    vecs[10] = '{4'b0110, 16'h0001, 16'h0014, 16'h0010, 3'b001, 1'b0, 1'b0, 1};
    vecs[11] = '{4'b0110, 16'h1234, 16'h0010, 16'h1234, 3'b100, 1'b0, 1'b0, 1};
    vecs[12] = '{4'b1000, 16'h8000, 16'h0003, 16'h1000, 3'b001, 1'b0, 1'b0, 1};
    vecs[13] = '{4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 3'b001, 1'b0, 1'b0, 1};
    vecs[14] = '{4'b1010, 16'd36,   16'hFFFA, 16'hFF28, 3'b100, 1'b0, 1'b0, 16};
    vecs[15] = '{4'b1010, 16'h0100, 16'h0100, 16'h0000, 3'b010, 1'b0, 1'b0, 16};
    vecs[16] = '{4'b1011, 16'd100,  16'd7,    16'd14,   3'b100, 1'b0, 1'b0, 16};
    vecs[17] = '{4'b1100, 16'd100,  16'd7,    16'd2,    3'b100, 1'b0, 1'b0, 16};
    vecs[18] = '{4'b1011, 16'd100,  16'd0,    16'hFFFF, 3'b100, 1'b1, 1'b0, 16};
    vecs[19] = '{4'b1100, 16'd100,  16'd0,    16'd100,  3'b100, 1'b1, 1'b0, 16};
    vecs[20] = '{4'b1011, 16'hFFFF, 16'd1,    16'hFFFF, 3'b001, 1'b0, 1'b0, 16};
    vecs[21] = '{4'b1100, 16'hFFFF, 16'd10,   16'd5,    3'b001, 1'b0, 1'b0, 16};
    vecs[22] = '{4'b1111, 16'd5,    16'd5,    16'h0000, 3'b010, 1'b0, 1'b1, 1};
    vecs[23] = '{4'b1101, 16'd1,    16'd2,    16'h0000, 3'b001, 1'b0, 1'b1, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset outputs", 32'({out_valid, out, comp, div0, illegal}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

    // Backpressure: arithmetic shift held for 10 cycles
    v = '{4'b0111, 16'h8000, 16'h0003, 16'hF000, 3'b001, 1'b0, 1'b0, 1};
    run_vec(v, 10, "backpressure");

    // Backpressure on a divide-by-zero result
    v = '{4'b1100, 16'h0ABC, 16'h0000, 16'h0ABC, 3'b100, 1'b1, 1'b0, 16};
    run_vec(v, 3, "bp_div0");

    // Reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; a = 16'd100; b = 16'd7; op = 4'b1011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out", 32'(out), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    chk("midreset flags", 32'({comp, div0, illegal}), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("midreset no late result", 32'(out_valid), 32'd0);
    v = '{4'b0000, 16'd3, 16'd4, 16'd7, 3'b001, 1'b0, 1'b0, 1};
    run_vec(v, 0, "after_reset_add");

    // Reset while a result is waiting in DONE
    @(negedge clk);
    in_valid = 1'b1; a = 16'd9; b = 16'd1; op = 4'b0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("done before reset out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("done reset outputs", 32'({out_valid, out, comp, div0, illegal}), 32'd0);
    chk("done reset in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
